adma_desc_fetch: RTL and testbench
==================================

// Module: adma_desc_fetch
// PURPOSE
// - ADMA2 descriptor fetch stage, directly upstream of the word-wide ram (address/read/data_out).
// - Walks a descriptor table, reading two 32-bit words per descriptor.
// - Decodes NOP / TRAN / LINK; presents each TRAN descriptor to the data-transfer engine over valid/ready.
// - Stops on END, error, or stop request.
// PARAMETERS
// - RAM_LAT   1    cycles from ram_read/ram_address to ram_data valid (>=1)
// - MAX_DESC  256  descriptors processed before loop-guard error (0 = unlimited)
// PORTS
// - CLK          in   1   clock, rising edge
// - RESET_L      in   1   asynchronous active-low reset
// - start        in   1   1-cycle pulse; begin fetch at start_addr (ignored unless IDLE/DONE/ERR)
// - start_addr   in   64  byte address of first descriptor
// - stop         in   1   abort request, honoured in any state
// - ram_address  out  64  byte address to ram
// - ram_read     out  1   ram read strobe
// - ram_data     in   32  ram read data
// - desc_valid   out  1   TRAN descriptor available
// - desc_ready   in   1   consumer accepts descriptor
// - desc_addr    out  32  data buffer address
// - desc_len     out  17  byte length (1..65536)
// - desc_int     out  1   INT attribute of presented descriptor
// - desc_last    out  1   END attribute of presented descriptor
// - busy         out  1   high in any state except IDLE/DONE/ERR
// - done         out  1   1-cycle pulse on normal END completion
// - error        out  1   sticky until next accepted start
// - err_addr     out  64  address of offending descriptor
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters 0.
// - Descriptor words:
//   - lo word at A: [0] VALID, [1] END, [2] INT, [5:4] ACT, [31:16] LEN
//   - hi word at A+4: ADDR
// - FSM: IDLE -> RD_LO -> WAIT_LO -> RD_HI -> WAIT_HI -> DECODE -> {OUT, RD_LO, DONE, ERR}
//   - RD_*: ram_read=1 for exactly one cycle; ram_address = A or A+4.
//   - WAIT_*: hold RAM_LAT cycles, then capture ram_data.
//   - ram_read is 0 in every other state.
//   - Uncontended fetch latency: 4+2*RAM_LAT cycles from RD_LO entry to DECODE.
// - DECODE:
//   - VALID=0 -> ERR.
//   - ACT=00 (NOP) or 01 (rsvd): skip; A += 8.
//   - ACT=10 (TRAN) -> OUT.
//   - ACT=11 (LINK): A = {32'h0, ADDR}; ADDR[2:0] != 0 -> ERR.
//   - END=1 on NOP/LINK/rsvd -> DONE after skip.
// - OUT: desc_valid=1; desc_* held stable until desc_valid && desc_ready.
//   - On that handshake cycle: END ? DONE : (A += 8; RD_LO).
//   - desc_valid never drops without a handshake, except stop/reset.
// - Address arithmetic: 64-bit, wraps modulo 2^64 silently.
// - Alignment: start_addr[2:0] != 0 -> ERR immediately; no ram access.
// - Loop guard: descriptor counter increments per DECODE; reaching MAX_DESC without END -> ERR.
// - DONE: pulse done one cycle, then IDLE.
// - ERR: error=1 and err_addr=A latched; stays in ERR until start.
// - stop: next state IDLE; desc_valid and ram_read drop the next cycle; error not set.
//   - stop and start in the same cycle: stop wins.
// - Async reset mid-operation: immediate return to reset values; no partial descriptor is presented.
// CONFIGURATION
// - ADMA_FETCH_LEN0_64K_EN defined: TRAN with LEN=0 is presented as desc_len = 65536.
// - Not defined: TRAN with LEN=0 -> ERR; desc_len max 65535, bit 16 always 0.
// STRUCTURE
// - Package adma_pkg: ACT_NOP/ACT_RSVD/ACT_TRAN/ACT_LINK codes; attribute bit positions;
//   FSM state encoding; DESC_BYTES=8.
// - Sub-module adma_desc_decode: combinational lo/hi word -> attribute/len/addr/error flags.
// TESTING
// - 3 TRAN descriptors at 0x100 (lens 0x200,0x10,0x40, last END), desc_ready=1
//   -> 3 handshakes in order, then done pulse; busy low after.
// - NOP at 0x0, LINK at 0x8 to 0x1000, TRAN+END at 0x1000
//   -> one descriptor out; ram_address sequence 0,4,8,C,1000,1004.
// - desc_ready held low 10 cycles in OUT -> desc_valid/desc_* stable throughout; no ram_read.
// - VALID=0 descriptor at 0x10 -> error=1, err_addr=0x10; start_addr=0x3 -> immediate error, no ram_read.
// - LEN=0 TRAN -> desc_len=0x10000 with ADMA_FETCH_LEN0_64K_EN, error without it;
//   LINK-to-self -> error after MAX_DESC DECODEs.
// - stop asserted in WAIT_HI, and RESET_L pulsed in OUT -> IDLE, all outputs 0, error unchanged/cleared.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA2 descriptor fetch stage: descriptor
// field positions, action codes, FSM encoding and the decoded-descriptor struct.
package adma_pkg;

    localparam int DESC_BYTES = 8;

    // Attribute bit positions in the descriptor lo word
    localparam int BIT_VALID = 0;
    localparam int BIT_END   = 1;
    localparam int BIT_INT   = 2;
    localparam int ACT_LSB   = 4;
    localparam int LEN_LSB   = 16;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSVD = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_e;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_LO, S_WAIT_LO, S_RD_HI, S_WAIT_HI,
        S_DECODE, S_OUT, S_DONE, S_ERR
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic        intr;
        act_e        act;
        logic [16:0] len;
        logic [31:0] addr;
        logic        len_err;
        logic        link_misalign;
    } desc_t;

endpackage

// File: rtl/adma_desc_fetch_if.sv
// RAM read port plus descriptor valid/ready output of the fetch stage.
// master = fetch stage side, slave = RAM / transfer engine side.
interface adma_desc_fetch_if;
    logic [63:0] ram_address;
    logic        ram_read;
    logic [31:0] ram_data;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_addr;
    logic [16:0] desc_len;
    logic        desc_int;
    logic        desc_last;

    modport master (
        output ram_address, ram_read, desc_valid, desc_addr, desc_len, desc_int, desc_last,
        input  ram_data, desc_ready
    );

    modport slave (
        input  ram_address, ram_read, desc_valid, desc_addr, desc_len, desc_int, desc_last,
        output ram_data, desc_ready
    );
endinterface

// File: rtl/adma_desc_decode.sv
// Combinational descriptor decode: lo/hi words -> attributes, length, address
// and error flags. Build option ADMA_FETCH_LEN0_64K_EN turns LEN=0 into a
// 64 KiB transfer instead of an error.
module adma_desc_decode
    import adma_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output desc_t       d
);
    logic [15:0] len_raw;
    logic        unused_bits;

    assign unused_bits = ^{lo[15:6], lo[3]};

    // Field extraction and per-action sanity flags
    always_comb begin
        len_raw         = lo[LEN_LSB +: 16];
        d.valid         = lo[BIT_VALID];
        d.last          = lo[BIT_END];
        d.intr          = lo[BIT_INT];
        d.act           = act_e'(lo[ACT_LSB +: 2]);
        d.addr          = hi;
        d.link_misalign = (d.act == ACT_LINK) && (hi[2:0] != 3'b000);
`ifdef ADMA_FETCH_LEN0_64K_EN
        d.len           = (len_raw == 16'h0) ? 17'h10000 : {1'b0, len_raw};
        d.len_err       = 1'b0;
`else
        d.len           = {1'b0, len_raw};
        d.len_err       = (d.act == ACT_TRAN) && (len_raw == 16'h0);
`endif
    end
endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA2 descriptor fetch stage. Walks the descriptor table two words at a
// time, skips NOP/reserved entries, follows LINKs and presents TRAN entries
// over valid/ready. Optional build macro: ADMA_FETCH_LEN0_64K_EN.
module adma_desc_fetch
    import adma_pkg::*;
#(
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned MAX_DESC = 256
) (
    input  logic                    CLK,
    input  logic                    RESET_L,
    input  logic                    start,
    input  logic [63:0]             start_addr,
    input  logic                    stop,
    adma_desc_fetch_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [63:0]             err_addr
);
    localparam int WW = $clog2(RAM_LAT + 1);
    localparam logic [WW-1:0] WLAST = WW'(RAM_LAT);

    state_e         state, state_n;
    logic [63:0]    a, a_n;
    logic [31:0]    lo, lo_n, hi, hi_n;
    logic [WW-1:0]  wcnt, wcnt_n;
    logic [31:0]    dcnt, dcnt_n, dcnt_inc;
    logic           err_n, go_err, guard, in_out;
    logic [63:0]    err_addr_n;
    desc_t          d;

    adma_desc_decode u_dec (.lo(lo), .hi(hi), .d(d));

    assign dcnt_inc = dcnt + 32'd1;
    assign guard    = (MAX_DESC != 0) && (dcnt_inc >= MAX_DESC);

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state    <= S_IDLE;
            a        <= '0;
            lo       <= '0;
            hi       <= '0;
            wcnt     <= '0;
            dcnt     <= '0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            state    <= state_n;
            a        <= a_n;
            lo       <= lo_n;
            hi       <= hi_n;
            wcnt     <= wcnt_n;
            dcnt     <= dcnt_n;
            error    <= err_n;
            err_addr <= err_addr_n;
        end
    end

    // Next-state: stop overrides everything, including a same-cycle start
    always_comb begin
        state_n    = state;
        a_n        = a;
        lo_n       = lo;
        hi_n       = hi;
        wcnt_n     = wcnt;
        dcnt_n     = dcnt;
        err_n      = error;
        err_addr_n = err_addr;
        go_err     = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (state == S_DONE) state_n = S_IDLE;
                    if (start) begin
                        a_n        = start_addr;
                        dcnt_n     = '0;
                        err_n      = 1'b0;
                        err_addr_n = '0;
                        state_n    = S_RD_LO;
                        if (start_addr[2:0] != 3'b000) begin
                            state_n    = S_ERR;
                            err_n      = 1'b1;
                            err_addr_n = start_addr;
                        end
                    end
                end
                S_RD_LO: begin
                    wcnt_n  = '0;
                    state_n = S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (wcnt == WLAST) begin
                        lo_n    = bus.ram_data;
                        state_n = S_RD_HI;
                    end else wcnt_n = wcnt + 1'b1;
                end
                S_RD_HI: begin
                    wcnt_n  = '0;
                    state_n = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (wcnt == WLAST) begin
                        hi_n    = bus.ram_data;
                        state_n = S_DECODE;
                    end else wcnt_n = wcnt + 1'b1;
                end
                S_DECODE: begin
                    dcnt_n = dcnt_inc;
                    if (!d.valid) go_err = 1'b1;
                    else begin
                        case (d.act)
                            ACT_TRAN: begin
                                if (d.len_err || (guard && !d.last)) go_err = 1'b1;
                                else state_n = S_OUT;
                            end
                            ACT_LINK: begin
                                if (d.link_misalign) go_err = 1'b1;
                                else if (d.last) state_n = S_DONE;
                                else if (guard) go_err = 1'b1;
                                else begin
                                    a_n     = {32'h0, d.addr};
                                    state_n = S_RD_LO;
                                end
                            end
                            default: begin
                                if (d.last) state_n = S_DONE;
                                else if (guard) go_err = 1'b1;
                                else begin
                                    a_n     = a + 64'(DESC_BYTES);
                                    state_n = S_RD_LO;
                                end
                            end
                        endcase
                    end
                end
                S_OUT: begin
                    if (bus.desc_ready) begin
                        if (d.last) state_n = S_DONE;
                        else begin
                            a_n     = a + 64'(DESC_BYTES);
                            state_n = S_RD_LO;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
            if (go_err) begin
                state_n    = S_ERR;
                err_n      = 1'b1;
                err_addr_n = a;
            end
        end
    end

    // Outputs decoded from state; descriptor fields are zero outside OUT
    assign in_out          = (state == S_OUT);
    assign bus.ram_read    = (state == S_RD_LO) || (state == S_RD_HI);
    assign bus.ram_address = (state == S_RD_LO) ? a :
                             (state == S_RD_HI) ? a + 64'd4 : 64'h0;
    assign bus.desc_valid  = in_out;
    assign bus.desc_addr   = in_out ? d.addr : 32'h0;
    assign bus.desc_len    = in_out ? d.len  : 17'h0;
    assign bus.desc_int    = in_out & d.intr;
    assign bus.desc_last   = in_out & d.last;
    assign busy            = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign done            = (state == S_DONE);
endmodule

// File: tb/tb_adma_desc_fetch.sv
// Scoreboard bench for adma_desc_fetch: a table-walking reference model
// predicts RAM reads and descriptor/done/error events; a negedge monitor
// pops and compares them as the DUT produces them.
module tb_adma_desc_fetch;
    localparam int MAXD = 256;

    logic        CLK = 1'b0, RESET_L = 1'b0, start = 1'b0, stop = 1'b0;
    logic [63:0] start_addr = 64'h0;
    logic        busy, done, error;
    logic [63:0] err_addr;
    logic        rdy = 1'b1;
    int          rdy_mode = 0;
    int          n_chk = 0, n_pass = 0;

    adma_desc_fetch_if bus();

    adma_desc_fetch #(.RAM_LAT(1), .MAX_DESC(MAXD)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .start(start), .start_addr(start_addr),
        .stop(stop), .bus(bus), .busy(busy), .done(done), .error(error),
        .err_addr(err_addr)
    );

    always #5 CLK = ~CLK;

    // RAM model, one cycle read latency, data held until next read
    logic [31:0] mem [logic [63:0]];
    logic [31:0] rdata = 32'h0;
    function automatic logic [31:0] memrd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction
    always @(posedge CLK) if (bus.ram_read) rdata <= memrd(bus.ram_address);
    assign bus.ram_data   = rdata;
    assign bus.desc_ready = rdy;

    // Consumer readiness: 0 always ready, 1 random, 2 stalled
    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom % 3) != 0;
            default: rdy = 1'b0;
        endcase
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    typedef struct { int kind; logic [63:0] v; } exp_t;  // 0 desc, 1 done, 2 err
    exp_t        exp_q[$];
    logic [63:0] rd_q[$];

    function automatic exp_t mk_exp(input int k, input logic [63:0] v);
        exp_t e;
        e.kind = k;
        e.v    = v;
        return e;
    endfunction

    function automatic logic [31:0] mk(input bit v, input bit e, input bit i,
                                       input logic [1:0] act, input logic [15:0] len);
        return {len, 10'h0, act, 1'b0, i, e, v};
    endfunction

    task automatic put(input logic [63:0] a, input logic [31:0] lo, input logic [31:0] hi);
        mem[a]         = lo;
        mem[a + 64'd4] = hi;
    endtask

    // Reference model: follow the table rules directly over the memory image
    task automatic walk(input logic [63:0] sa);
        logic [63:0] a;
        logic [31:0] lo, hi;
        logic [16:0] len;
        bit          guard, last;
        if (sa[2:0] != 3'b0) begin exp_q.push_back(mk_exp(2, sa)); return; end
        a = sa;
        for (int n = 1; n <= MAXD + 2; n++) begin
            rd_q.push_back(a);
            rd_q.push_back(a + 64'd4);
            lo    = memrd(a);
            hi    = memrd(a + 64'd4);
            last  = lo[1];
            guard = (n >= MAXD) && !last;
            if (!lo[0]) begin exp_q.push_back(mk_exp(2, a)); return; end
            if (lo[5:4] == 2'b10) begin
                len = (lo[31:16] == 16'h0) ? 17'h10000 : {1'b0, lo[31:16]};
`ifndef ADMA_FETCH_LEN0_64K_EN
                if (lo[31:16] == 16'h0) begin exp_q.push_back(mk_exp(2, a)); return; end
`endif
                if (guard) begin exp_q.push_back(mk_exp(2, a)); return; end
                exp_q.push_back(mk_exp(0, {13'h0, hi, len, lo[2], last}));
                if (last) begin exp_q.push_back(mk_exp(1, 0)); return; end
                a = a + 64'd8;
            end else if (lo[5:4] == 2'b11) begin
                if (hi[2:0] != 3'b0) begin exp_q.push_back(mk_exp(2, a)); return; end
                if (last) begin exp_q.push_back(mk_exp(1, 0)); return; end
                if (guard) begin exp_q.push_back(mk_exp(2, a)); return; end
                a = {32'h0, hi};
            end else begin
                if (last) begin exp_q.push_back(mk_exp(1, 0)); return; end
                if (guard) begin exp_q.push_back(mk_exp(2, a)); return; end
                a = a + 64'd8;
            end
        end
    endtask

    // Monitor: pop expected reads/events as the DUT presents them
    logic err_prev = 1'b0;
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RESET_L) begin
            if (bus.ram_read) begin
                if (rd_q.size() == 0) chk("unexpected_read", bus.ram_address, 64'hDEAD);
                else chk("ram_address", bus.ram_address, rd_q.pop_front());
            end
            if (bus.desc_valid && bus.desc_ready) begin
                if (exp_q.size() == 0) chk("unexpected_desc", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("desc_kind", 64'(e.kind), 0);
                    chk("desc_fields", {13'h0, bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_last}, e.v);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin e = exp_q.pop_front(); chk("done_kind", 64'(e.kind), 1); end
            end
            if (error && !err_prev) begin
                if (exp_q.size() == 0) chk("unexpected_error", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("err_kind", 64'(e.kind), 2);
                    chk("err_addr", err_addr, e.v);
                end
            end
        end
        err_prev = error;
    end

    task automatic do_reset();
        RESET_L = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        mem.delete();
        @(negedge CLK);
    endtask

    task automatic pulse(input logic [63:0] sa);
        start_addr = sa;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("events_left", 64'(exp_q.size()), 0);
        repeat (3) @(negedge CLK);
        chk("reads_left", 64'(rd_q.size()), 0);
        exp_q.delete();
        rd_q.delete();
    endtask

    task automatic run(input logic [63:0] sa, input int mode);
        rdy_mode = mode;
        walk(sa);
        pulse(sa);
        wait_done();
    endtask

    task automatic wait_valid(output bit found);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            found = bus.desc_valid;
        end
    endtask

    initial begin
        bit          found, ok;
        logic [63:0] snap, cur, base;
        logic [31:0] lo, tgt;
        logic [1:0]  act;
        int          k;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_ctl", {busy, done, error, bus.desc_valid, bus.ram_read}, 0);
        chk("rst_addr", bus.ram_address | err_addr, 0);
        chk("rst_desc", {bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_last}, 0);
        RESET_L = 1'b1;
        @(negedge CLK);

        // Three TRANs, always ready
        do_reset();
        put(64'h100, mk(1, 0, 0, 2'b10, 16'h200), 32'hA000);
        put(64'h108, mk(1, 0, 1, 2'b10, 16'h10),  32'hB000);
        put(64'h110, mk(1, 1, 0, 2'b10, 16'h40),  32'hC000);
        run(64'h100, 0);
        chk("busy_after", busy, 0);

        // NOP, LINK to 0x1000, TRAN+END
        do_reset();
        put(64'h0,    mk(1, 0, 0, 2'b00, 16'h0),  32'h0);
        put(64'h8,    mk(1, 0, 0, 2'b11, 16'h0),  32'h1000);
        put(64'h1000, mk(1, 1, 1, 2'b10, 16'h80), 32'hD000);
        run(64'h0, 0);

        // VALID=0 descriptor at 0x10, then misaligned start
        do_reset();
        put(64'h0, mk(1, 0, 1, 2'b10, 16'h10), 32'h1111);
        put(64'h8, mk(1, 0, 0, 2'b01, 16'h0),  32'h0);
        run(64'h0, 0);
        do_reset();
        run(64'h3, 0);

        // LEN=0 TRAN, then LINK-to-self loop guard
        do_reset();
        put(64'h600, mk(1, 1, 0, 2'b10, 16'h0), 32'hE000);
        run(64'h600, 0);
        do_reset();
        put(64'h40, mk(1, 0, 0, 2'b11, 16'h0), 32'h40);
        run(64'h40, 0);

        // Consumer stall: outputs frozen, no RAM traffic
        do_reset();
        put(64'h500, mk(1, 1, 1, 2'b10, 16'h20), 32'h5555_0000);
        rdy_mode = 2;
        walk(64'h500);
        pulse(64'h500);
        wait_valid(found);
        chk("stall_reach", 64'(found), 1);
        snap = {13'h0, bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_last};
        ok = 1;
        repeat (10) begin
            @(negedge CLK);
            if (!bus.desc_valid || bus.ram_read ||
                {13'h0, bus.desc_addr, bus.desc_len, bus.desc_int, bus.desc_last} != snap) ok = 0;
        end
        chk("stall_stable", 64'(ok), 1);
        rdy_mode = 0;
        wait_done();

        // stop during WAIT_HI
        do_reset();
        put(64'h200, mk(1, 1, 0, 2'b10, 16'h8), 32'hAAAA_0000);
        rd_q.push_back(64'h200);
        rd_q.push_back(64'h204);
        pulse(64'h200);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            found = bus.ram_read && (bus.ram_address == 64'h204);
        end
        chk("stop_reach", 64'(found), 1);
        @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        chk("stop_idle", {busy, bus.desc_valid, bus.ram_read, done, error}, 0);
        repeat (5) @(negedge CLK);
        chk("stop_quiet", {busy, bus.desc_valid}, 0);
        chk("stop_reads", 64'(rd_q.size()), 0);
        rd_q.delete();

        // stop in ERR keeps the sticky error
        do_reset();
        run(64'h3, 0);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        @(negedge CLK);
        chk("stop_err_flag", {busy, error}, 1);
        chk("stop_err_addr", err_addr, 64'h3);

        // Async reset while presenting a descriptor
        do_reset();
        put(64'h300, mk(1, 0, 0, 2'b10, 16'h40), 32'h1234_5678);
        rd_q.push_back(64'h300);
        rd_q.push_back(64'h304);
        rdy_mode = 2;
        pulse(64'h300);
        wait_valid(found);
        chk("rst_out_reach", 64'(found), 1);
        RESET_L = 1'b0;
        #1;
        chk("rst_async_ctl", {busy, bus.desc_valid, bus.ram_read, error, done}, 0);
        chk("rst_async_desc", {bus.desc_addr, bus.desc_len}, 0);
        @(negedge CLK);
        RESET_L = 1'b1;
        rdy_mode = 0;
        repeat (5) @(negedge CLK);
        chk("rst_quiet", {busy, bus.desc_valid, bus.ram_read}, 0);
        chk("rst_reads", 64'(rd_q.size()), 0);
        rd_q.delete();

        // Randomized tables, including one wrapping past 2^64
        for (int t = 0; t < 40; t++) begin
            do_reset();
            base = (t == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : 64'($urandom_range(0, 255)) << 8;
            if ($urandom % 16 == 0) base = base + 64'd4;
            cur = base;
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                case ($urandom % 5)
                    0: act = 2'b00;
                    1: act = 2'b01;
                    4: act = 2'b11;
                    default: act = 2'b10;
                endcase
                lo = mk($urandom % 20 != 0, (i == k - 1) && ($urandom % 8 != 0),
                        $urandom % 2 == 1, act,
                        ($urandom % 8 == 0) ? 16'h0 : 16'($urandom));
                if (act == 2'b11) begin
                    tgt = 32'h0001_0000 + 32'(t) * 32'h1000 + 32'(i) * 32'h100;
                    if ($urandom % 8 == 0) tgt = tgt + 32'd2;
                    put(cur, lo, tgt);
                    cur = {32'h0, tgt};
                end else begin
                    put(cur, lo, $urandom);
                    cur = cur + 64'd8;
                end
            end
            run(base, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
